// File: rtl/guess_pkg.sv
// Shared types and default parameters for the digit guessing game controller.
// The GUESS_INPUT_SYNC_EN build option lives in btn_edge.
package guess_pkg;

    typedef enum logic [1:0] {
        ST_SET   = 2'd0,
        ST_GUESS = 2'd1,
        ST_WIN   = 2'd2,
        ST_LOSE  = 2'd3
    } state_t;

    // Digit code is (button number - 1), so buttons 1..4 map to 0..3
    typedef logic [1:0] digit_t;

    typedef enum logic [1:0] {
        CMP_EQUAL   = 2'd0,
        CMP_BIGGER  = 2'd1,
        CMP_SMALLER = 2'd2
    } cmp_t;

    localparam int DEF_MIN_DIGITS = 4;
    localparam int DEF_MAX_DIGITS = 8;
    localparam int DEF_MAX_TRIES  = 3;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one front-panel input, with an optional 2-flop
// synchroniser in front when GUESS_INPUT_SYNC_EN is defined.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic sampled;
    logic level_q;
    logic level_d_q;

`ifdef GUESS_INPUT_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], din};
        end
    end

    assign sampled = sync_q[1];
`else
    assign sampled = din;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q   <= 1'b0;
            level_d_q <= 1'b0;
        end else begin
            level_q   <= sampled;
            level_d_q <= level_q;
        end
    end

    // One pulse per press, no matter how long the button is held
    assign pulse = level_q & ~level_d_q;

endmodule

// File: rtl/test.sv
// Two-player digit guessing game: secret entry, guess evaluation and win/lose.
// Define GUESS_INPUT_SYNC_EN to synchronise the button inputs (see btn_edge).
//
// state    | meaning
// ---------+--------------------------------------------
// ST_SET   | player A keys the secret
// ST_GUESS | player B keys guesses, flags show last result
// ST_WIN   | guess matched, everything frozen until reset
// ST_LOSE  | tries exhausted, everything frozen until reset
module test
    import guess_pkg::*;
#(
    parameter int MIN_DIGITS = DEF_MIN_DIGITS,
    parameter int MAX_DIGITS = DEF_MAX_DIGITS,
    parameter int MAX_TRIES  = DEF_MAX_TRIES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       I1,
    input  logic       I2,
    input  logic       I3,
    input  logic       I4,
    input  logic       enter,
    output logic       win,
    output logic       lose,
    output logic       equal,
    output logic       bigger,
    output logic       smaller,
    output logic [0:3] nums
);

    localparam int EW = 2 * MAX_DIGITS;
    localparam int TW = $clog2(MAX_TRIES + 1);

    logic [4:0] raw;
    logic [4:0] pulse;

    assign raw = {enter, I4, I3, I2, I1};

    for (genvar i = 0; i < 5; i++) begin : g_edge
        btn_edge u_edge (
            .clk   (clk),
            .rst_n (reset),
            .din   (raw[i]),
            .pulse (pulse[i])
        );
    end

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [EW-1:0]  entry_q, entry_d;
    logic [EW-1:0]  secret_q, secret_d;
    logic [3:0]     slen_q, slen_d;
    logic [TW-1:0]  tries_q, tries_d;
    logic           win_q, win_d;
    logic           lose_q, lose_d;
    logic           equal_q, equal_d;
    logic           bigger_q, bigger_d;
    logic           smaller_q, smaller_d;

    logic           digit_ok;
    digit_t         digit;
    logic           ent;
    logic [3:0]     app_cnt;
    logic [EW-1:0]  app_entry;
    cmp_t           cmp;
    logic           last_try;

    assign ent = pulse[4];

    // Simultaneous presses of several digit buttons are ambiguous and dropped
    always_comb begin
        digit_ok = 1'b0;
        digit    = 2'd0;
        case (pulse[3:0])
            4'b0001: begin digit_ok = 1'b1; digit = 2'd0; end
            4'b0010: begin digit_ok = 1'b1; digit = 2'd1; end
            4'b0100: begin digit_ok = 1'b1; digit = 2'd2; end
            4'b1000: begin digit_ok = 1'b1; digit = 2'd3; end
            default: ;
        endcase
    end

    // Digits are shifted in from the right, so for equal lengths the packed
    // value orders the same way as the decimal number
    always_comb begin
        app_cnt   = cnt_q;
        app_entry = entry_q;
        if (digit_ok && (int'(cnt_q) < MAX_DIGITS)) begin
            app_cnt   = cnt_q + 4'd1;
            app_entry = {entry_q[EW-3:0], digit};
        end
    end

    function automatic cmp_t compare(input logic [3:0]    g_len,
                                     input logic [EW-1:0] g_val,
                                     input logic [3:0]    s_len,
                                     input logic [EW-1:0] s_val);
        if (g_len > s_len) return CMP_BIGGER;
        if (g_len < s_len) return CMP_SMALLER;
        if (g_val > s_val) return CMP_BIGGER;
        if (g_val < s_val) return CMP_SMALLER;
        return CMP_EQUAL;
    endfunction

    assign cmp      = compare(app_cnt, app_entry, slen_q, secret_q);
    assign last_try = (int'(tries_q) + 1 >= MAX_TRIES);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        entry_d   = entry_q;
        secret_d  = secret_q;
        slen_d    = slen_q;
        tries_d   = tries_q;
        win_d     = win_q;
        lose_d    = lose_q;
        equal_d   = equal_q;
        bigger_d  = bigger_q;
        smaller_d = smaller_q;

        case (state_q)
            ST_SET: begin
                cnt_d   = app_cnt;
                entry_d = app_entry;
                if (ent) begin
                    cnt_d   = 4'd0;
                    entry_d = '0;
                    if (int'(app_cnt) >= MIN_DIGITS) begin
                        secret_d = app_entry;
                        slen_d   = app_cnt;
                        state_d  = ST_GUESS;
                    end
                end
            end

            ST_GUESS: begin
                cnt_d   = app_cnt;
                entry_d = app_entry;
                if (ent) begin
                    cnt_d   = 4'd0;
                    entry_d = '0;
                    if (int'(app_cnt) >= MIN_DIGITS) begin
                        equal_d   = (cmp == CMP_EQUAL);
                        bigger_d  = (cmp == CMP_BIGGER);
                        smaller_d = (cmp == CMP_SMALLER);
                        if (cmp == CMP_EQUAL) begin
                            win_d   = 1'b1;
                            state_d = ST_WIN;
                        end else begin
                            tries_d = tries_q + TW'(1);
                            if (last_try) begin
                                lose_d  = 1'b1;
                                state_d = ST_LOSE;
                            end
                        end
                    end
                end
            end

            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_SET;
            cnt_q     <= 4'd0;
            entry_q   <= '0;
            secret_q  <= '0;
            slen_q    <= 4'd0;
            tries_q   <= '0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
            equal_q   <= 1'b0;
            bigger_q  <= 1'b0;
            smaller_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            entry_q   <= entry_d;
            secret_q  <= secret_d;
            slen_q    <= slen_d;
            tries_q   <= tries_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
            equal_q   <= equal_d;
            bigger_q  <= bigger_d;
            smaller_q <= smaller_d;
        end
    end

    assign win     = win_q;
    assign lose    = lose_q;
    assign equal   = equal_q;
    assign bigger  = bigger_q;
    assign smaller = smaller_q;
    assign nums    = cnt_q;

endmodule

// File: tb/tb_test.sv
// Bench for the guessing game: directed scenarios plus random games against
// a queue-based reference model of the game rules.
module tb_test;

    localparam int MIN_D = 4;
    localparam int MAX_D = 8;
    localparam int MAX_T = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       I1, I2, I3, I4, enter;
    logic       win, lose, equal, bigger, smaller;
    logic [0:3] nums;

    test dut (
        .clk     (clk),
        .reset   (reset),
        .I1      (I1),
        .I2      (I2),
        .I3      (I3),
        .I4      (I4),
        .enter   (enter),
        .win     (win),
        .lose    (lose),
        .equal   (equal),
        .bigger  (bigger),
        .smaller (smaller),
        .nums    (nums)
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_miscmp = 0;
    string cur_tag = "init";

    // Reference model: entry and secret kept as digit queues (values 1..4)
    int m_ent[$];
    int m_sec[$];
    bit m_set, m_over;
    int m_tries;
    bit m_win, m_lose, m_eq, m_big, m_sml;

    function automatic longint to_num(input int q[$]);
        longint v = 0;
        foreach (q[i]) v = v * 10 + q[i];
        return v;
    endfunction

    task automatic m_reset();
        m_ent.delete();
        m_sec.delete();
        m_set = 0; m_over = 0; m_tries = 0;
        m_win = 0; m_lose = 0; m_eq = 0; m_big = 0; m_sml = 0;
    endtask

    task automatic m_digit(input int d);
        if (!m_over && m_ent.size() < MAX_D) m_ent.push_back(d);
    endtask

    task automatic m_enter();
        longint gv, sv;
        if (m_over) return;
        if (!m_set) begin
            if (m_ent.size() >= MIN_D) begin
                m_sec = m_ent;
                m_set = 1;
            end
        end else if (m_ent.size() >= MIN_D) begin
            gv = to_num(m_ent);
            sv = to_num(m_sec);
            m_eq = 0; m_big = 0; m_sml = 0;
            if (m_ent.size() > m_sec.size())      m_big = 1;
            else if (m_ent.size() < m_sec.size()) m_sml = 1;
            else if (gv > sv)                     m_big = 1;
            else if (gv < sv)                     m_sml = 1;
            else                                  m_eq  = 1;
            if (m_eq) begin
                m_win = 1; m_over = 1;
            end else begin
                m_tries++;
                if (m_tries == MAX_T) begin
                    m_lose = 1; m_over = 1;
                end
            end
        end
        m_ent.delete();
    endtask

    task automatic chk(input string name, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miscmp++;
            $error("FAIL %s/%s: observed %0d expected %0d", cur_tag, name, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("nums",    int'(nums),    m_ent.size());
        chk("win",     int'(win),     int'(m_win));
        chk("lose",    int'(lose),    int'(m_lose));
        chk("equal",   int'(equal),   int'(m_eq));
        chk("bigger",  int'(bigger),  int'(m_big));
        chk("smaller", int'(smaller), int'(m_sml));
    endtask

    // Hold long enough for the synchronised build too, then release and settle
    task automatic drive(input logic [3:0] dmask, input logic ent);
        @(negedge clk);
        {I4, I3, I2, I1} = dmask;
        enter = ent;
        repeat (3) @(negedge clk);
        {I4, I3, I2, I1} = 4'b0000;
        enter = 1'b0;
        repeat (4) @(negedge clk);
        if ($countones(dmask) == 1) begin
            for (int d = 1; d <= 4; d++) if (dmask[d-1]) m_digit(d);
        end
        if (ent) m_enter();
        check_all();
    endtask

    task automatic key(input int d);
        drive(4'(1 << (d - 1)), 1'b0);
    endtask

    task automatic press_enter();
        drive(4'b0000, 1'b1);
    endtask

    task automatic type_str(input string s, input bit commit);
        for (int i = 0; i < s.len(); i++) key(int'(s[i]) - 48);
        if (commit) press_enter();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        m_reset();
        check_all();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic type_random(input int len, input bit merge_enter);
        int d;
        logic [3:0] multi[8] = '{4'b0011, 4'b0101, 4'b0110, 4'b1001,
                                 4'b1010, 4'b1100, 4'b0111, 4'b1111};
        for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 9) == 0) drive(multi[$urandom_range(0, 7)], 1'b0);
            d = int'($urandom_range(1, 4));
            if (merge_enter && k == len - 1) drive(4'(1 << (d - 1)), 1'b1);
            else key(d);
        end
        if (!merge_enter || len == 0) press_enter();
    endtask

    task automatic type_secret_copy(input bit tweak);
        int q[$];
        q = m_sec;
        if (tweak) q[q.size() - 1] = (q[q.size() - 1] % 4) + 1;
        foreach (q[i]) key(q[i]);
        press_enter();
    endtask

    initial begin
        reset = 1'b0;
        {I4, I3, I2, I1} = 4'b0000;
        enter = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        cur_tag = "reset";
        check_all();
        reset = 1'b1;
        @(negedge clk);

        cur_tag = "win_first";
        type_str("1234", 1);
        type_str("1234", 1);
        chk("win_const", int'(win), 1);

        cur_tag = "smaller_then_win";
        do_reset();
        type_str("42413", 1);
        type_str("4241", 1);
        type_str("42413", 1);

        cur_tag = "win_third";
        do_reset();
        type_str("14321", 1);
        type_str("1234", 1);
        type_str("12341", 1);
        type_str("14321", 1);

        cur_tag = "lose";
        do_reset();
        type_str("14321", 1);
        type_str("1234", 1);
        type_str("12341", 1);
        type_str("14324", 1);
        chk("lose_const", int'(lose), 1);
        type_str("14321", 1);
        key(2);

        cur_tag = "short_secret";
        do_reset();
        type_str("123", 1);
        type_str("12", 1);
        type_str("1234", 1);
        type_str("12", 1);
        type_str("1234", 1);

        cur_tag = "reset_mid";
        do_reset();
        type_str("2222", 1);
        type_str("21", 0);
        do_reset();
        type_str("1111", 1);
        type_str("1111", 1);

        cur_tag = "saturate_merge";
        do_reset();
        type_str("1234123412", 0);
        drive(4'b0100, 1'b1);
        type_str("432", 0);
        drive(4'b0001, 1'b1);
        drive(4'b0011, 1'b0);
        drive(4'b0000, 1'b1);

        cur_tag = "random";
        for (int g = 0; g < 25; g++) begin
            do_reset();
            type_random(int'($urandom_range(2, 9)), bit'($urandom_range(0, 1)));
            if (!m_set) type_random(int'($urandom_range(4, 8)), 1'b0);
            for (int t = 0; t < 6 && !m_over; t++) begin
                case ($urandom_range(0, 3))
                    0: type_secret_copy(1'b0);
                    1: type_secret_copy(1'b1);
                    default: type_random(int'($urandom_range(3, 9)),
                                         bit'($urandom_range(0, 1)));
                endcase
            end
            key(int'($urandom_range(1, 4)));
            press_enter();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
